native_port_arbiter: RTL and testbench
======================================

# native_port_arbiter

Two-requester arbiter that shares one DMA native port of the LPDDR4 controller between two upstream DMA masters. Commands are granted round-robin. Each accepted command's owner is recorded in an in-order tracking FIFO so that write data is taken from the correct master and read data is steered back to the issuing master. It sits between the DMA engines and the controller's native command/wdata/rdata channels, and adds no latency on the data paths.

## Interface
Parameters:
- DDR_DATA_W, 128: native data beat width.
- DDR_MASK_W, DDR_DATA_W/8: write byte-enable width.
- DDR_ADDR_W, 28: native command address width.
- OUTSTANDING, 8: depth of each owner FIFO (read and write). Must be a power of 2 and at least 2.

Ports (x = 0, 1 for each requester):
- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset.
- ux_ncmd_valid_i  input  1  requester command valid.
- ux_ncmd_ready_o  output  1  requester command accepted.
- ux_ncmd_payload_addr_i  input  DDR_ADDR_W  command address.
- ux_ncmd_payload_we_i  input  1  1 = write, 0 = read.
- ux_ncmd_payload_mw_i  input  1  masked write; only meaningful when we = 1.
- ux_wdata_valid_i / ux_wdata_ready_o  input / output  1  requester write-data handshake.
- ux_wdata_payload_data_i  input  DDR_DATA_W  write data.
- ux_wdata_payload_we_i  input  DDR_MASK_W  byte enables.
- ux_rdata_valid_o / ux_rdata_ready_i  output / input  1  requester read-data handshake.
- ux_rdata_payload_data_o  output  DDR_DATA_W  read data.
- ncmd_valid_o, ncmd_ready_i, ncmd_payload_addr_o, ncmd_payload_we_o, ncmd_payload_mw_o  downstream command channel; widths as above.
- wdata_valid_o, wdata_ready_i, wdata_payload_data_o, wdata_payload_we_o  downstream write-data channel.
- rdata_valid_i, rdata_ready_o, rdata_payload_data_i  downstream read-data channel.
- err_o  output  1  sticky protocol error; cleared only by rst.

## Operation
- Transfer unit: one command equals exactly one data beat on the matching channel.
- A handshake completes on any cycle where valid and ready are both 1.
- Command arbitration:
  - Eligible requester: ux_ncmd_valid_i = 1 and the owner FIFO for its command type is not full.
  - Full means count == OUTSTANDING. Push is blocked at full even if a pop happens in the same cycle.
  - Round-robin pointer `prio` names the preferred requester. If both requesters are eligible, grant goes to `prio`; if only one is eligible, it is granted.
  - The selected requester's payload is muxed to ncmd_*. ncmd_valid_o = 1 when any requester is eligible.
  - ux_ncmd_ready_o = ncmd_ready_i for the granted requester and 0 for the other.
  - On a command handshake, `prio` is set to the other requester.
- Grant lock:
  - If ncmd_valid_o = 1 and ncmd_ready_i = 0, register `lock` = 1 and `lock_id` = the granted requester.
  - While `lock` = 1, the grant stays on `lock_id` regardless of the other requester.
  - `lock` clears on the next command handshake.
  - Requesters must hold valid and payload stable until accepted.
- Write tracking:
  - A write command handshake pushes the owner id into wfifo.
  - When wfifo is not empty, its head selects which requester drives wdata_*: wdata_valid_o = u[head]_wdata_valid_i, and u[head]_wdata_ready_o = wdata_ready_i.
  - When wfifo is empty, wdata_valid_o = 0 and both ux_wdata_ready_o = 0.
  - A wdata handshake pops wfifo.
- Read tracking:
  - A read command handshake pushes the owner id into rfifo.
  - rdata_payload_data_i is broadcast to both ux_rdata_payload_data_o.
  - u[head]_rdata_valid_o = rdata_valid_i, and rdata_ready_o = u[head]_rdata_ready_i.
  - An rdata handshake pops rfifo.
- Error handling:
  - If rdata_valid_i = 1 while rfifo is empty: rdata_ready_o = 1 (the beat is dropped), no requester sees valid, and err_o sets.
  - If wdata_ready_i = 1 while wfifo is empty: no action.
- FIFO counts are $clog2(OUTSTANDING)+1 bits wide. Read and write pointers wrap modulo OUTSTANDING.
- Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.

## Timing
- Reset values: `prio` = 0, `lock` = 0, both FIFOs empty, err_o = 0.
- While rst = 1:
  - All ready outputs and valid outputs are 0, including rdata_ready_o.
  - ncmd_payload_*_o and wdata_payload_*_o are 0.
- Command path is combinational: zero cycles from ux_ncmd_valid_i to ncmd_valid_o.
- A write command accepted in cycle N makes wdata routable from cycle N+1. Write data is never forwarded in the same cycle as its own command.
- Read data path is combinational: zero-cycle valid/ready/data forwarding.
- Reset asserted mid-transaction discards all owner state. Beats still outstanding downstream after reset are handled by the error rule above.
- Maximum throughput: one command per cycle, alternating requesters when both are continuously eligible.

## Test plan
- Reset and idle:
  - Drive rst for 2 cycles with both requesters valid.
  - Required: all valid and ready outputs are 0.
  - In the first cycle after reset, both request a read with ncmd_ready_i = 1; u0 is granted first, then u1, alternating.
- Lock under backpressure:
  - u1 requests alone with ncmd_ready_i = 0 for 3 cycles, and u0 raises valid in cycle 1.
  - Required: ncmd_payload_addr_o stays at u1's address until accepted; u0 is granted on the next cycle.
- Write ordering:
  - u0 writes A, then u1 writes B; u1 presents wdata first.
  - Required: u1_wdata_ready_o = 0 until u0's beat transfers; downstream data order is u0's beat then u1's beat.
- Read return steering:
  - Issue reads u1, u0, u1, then return 3 beats 0x11, 0x22, 0x33.
  - Required: u1 receives 0x11 and 0x33, and u0 receives 0x22.
  - Holding u0_rdata_ready_i = 0 stalls rdata_ready_o.
- FIFO full:
  - Issue OUTSTANDING reads with no return.
  - Required: the (OUTSTANDING+1)th read is not accepted and a write from the other requester is still granted.
  - After one rdata pop, the blocked read is accepted on the following cycle.
- Spurious rdata:
  - Assert rdata_valid_i with rfifo empty.
  - Required: rdata_ready_o = 1, both ux_rdata_valid_o = 0, and err_o = 1 from the next cycle until rst.

Source files
------------

// File: rtl/native_port_arbiter.sv
// rtl/native_port_arbiter.sv - round-robin arbiter sharing one native DDR port between two DMA masters
// Per-type owner FIFOs steer write data from, and read data back to, the master that issued each command.
module native_port_arbiter #(
  parameter int DDR_DATA_W  = 128,
  parameter int DDR_MASK_W  = DDR_DATA_W / 8,
  parameter int DDR_ADDR_W  = 28,
  parameter int OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  u0_ncmd_valid_i,
  output logic                  u0_ncmd_ready_o,
  input  logic [DDR_ADDR_W-1:0] u0_ncmd_payload_addr_i,
  input  logic                  u0_ncmd_payload_we_i,
  input  logic                  u0_ncmd_payload_mw_i,
  input  logic                  u0_wdata_valid_i,
  output logic                  u0_wdata_ready_o,
  input  logic [DDR_DATA_W-1:0] u0_wdata_payload_data_i,
  input  logic [DDR_MASK_W-1:0] u0_wdata_payload_we_i,
  output logic                  u0_rdata_valid_o,
  input  logic                  u0_rdata_ready_i,
  output logic [DDR_DATA_W-1:0] u0_rdata_payload_data_o,
  input  logic                  u1_ncmd_valid_i,
  output logic                  u1_ncmd_ready_o,
  input  logic [DDR_ADDR_W-1:0] u1_ncmd_payload_addr_i,
  input  logic                  u1_ncmd_payload_we_i,
  input  logic                  u1_ncmd_payload_mw_i,
  input  logic                  u1_wdata_valid_i,
  output logic                  u1_wdata_ready_o,
  input  logic [DDR_DATA_W-1:0] u1_wdata_payload_data_i,
  input  logic [DDR_MASK_W-1:0] u1_wdata_payload_we_i,
  output logic                  u1_rdata_valid_o,
  input  logic                  u1_rdata_ready_i,
  output logic [DDR_DATA_W-1:0] u1_rdata_payload_data_o,
  output logic                  ncmd_valid_o,
  input  logic                  ncmd_ready_i,
  output logic [DDR_ADDR_W-1:0] ncmd_payload_addr_o,
  output logic                  ncmd_payload_we_o,
  output logic                  ncmd_payload_mw_o,
  output logic                  wdata_valid_o,
  input  logic                  wdata_ready_i,
  output logic [DDR_DATA_W-1:0] wdata_payload_data_o,
  output logic [DDR_MASK_W-1:0] wdata_payload_we_o,
  input  logic                  rdata_valid_i,
  output logic                  rdata_ready_o,
  input  logic [DDR_DATA_W-1:0] rdata_payload_data_i,
  output logic                  err_o
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  logic                   r_prio;
  logic                   r_lock;
  logic                   r_lock_id;
  logic                   r_err;
  logic [OUTSTANDING-1:0] r_wmem;
  logic [OUTSTANDING-1:0] r_rmem;
  logic [PW-1:0]          r_wrp, r_wwp, r_rrp, r_rwp;
  logic [CW-1:0]          r_wcnt, r_rcnt;

  logic w_wfull, w_rfull, w_wempty, w_rempty;
  logic w_elig0, w_elig1, w_gnt, w_cmd_valid, w_cmd_fire, w_cmd_we;
  logic w_whead, w_rhead, w_wvalid, w_wpush, w_wpop, w_rready, w_rpush, w_rpop;

  assign w_wfull  = (r_wcnt == CW'(OUTSTANDING));
  assign w_rfull  = (r_rcnt == CW'(OUTSTANDING));
  assign w_wempty = (r_wcnt == '0);
  assign w_rempty = (r_rcnt == '0);

  // A requester is only eligible if the owner FIFO for its command type can take the push.
  assign w_elig0 = u0_ncmd_valid_i & ~(u0_ncmd_payload_we_i ? w_wfull : w_rfull);
  assign w_elig1 = u1_ncmd_valid_i & ~(u1_ncmd_payload_we_i ? w_wfull : w_rfull);

  assign w_gnt       = r_lock ? r_lock_id : ((w_elig0 & w_elig1) ? r_prio : w_elig1);
  assign w_cmd_valid = ~rst & (w_gnt ? w_elig1 : w_elig0);
  assign w_cmd_fire  = w_cmd_valid & ncmd_ready_i;
  assign w_cmd_we    = w_gnt ? u1_ncmd_payload_we_i : u0_ncmd_payload_we_i;

  assign ncmd_valid_o        = w_cmd_valid;
  assign u0_ncmd_ready_o     = w_cmd_valid & ~w_gnt & ncmd_ready_i;
  assign u1_ncmd_ready_o     = w_cmd_valid & w_gnt & ncmd_ready_i;
  assign ncmd_payload_addr_o = rst ? '0 : (w_gnt ? u1_ncmd_payload_addr_i : u0_ncmd_payload_addr_i);
  assign ncmd_payload_we_o   = ~rst & w_cmd_we;
  assign ncmd_payload_mw_o   = ~rst & (w_gnt ? u1_ncmd_payload_mw_i : u0_ncmd_payload_mw_i);

  assign w_whead              = r_wmem[r_wrp];
  assign w_wvalid             = ~rst & ~w_wempty & (w_whead ? u1_wdata_valid_i : u0_wdata_valid_i);
  assign wdata_valid_o        = w_wvalid;
  assign u0_wdata_ready_o     = ~rst & ~w_wempty & ~w_whead & wdata_ready_i;
  assign u1_wdata_ready_o     = ~rst & ~w_wempty & w_whead & wdata_ready_i;
  assign wdata_payload_data_o = rst ? '0 : (w_whead ? u1_wdata_payload_data_i : u0_wdata_payload_data_i);
  assign wdata_payload_we_o   = rst ? '0 : (w_whead ? u1_wdata_payload_we_i : u0_wdata_payload_we_i);
  assign w_wpush              = w_cmd_fire & w_cmd_we;
  assign w_wpop               = w_wvalid & wdata_ready_i;

  // With no owner recorded, an incoming read beat is accepted and dropped.
  assign w_rhead                 = r_rmem[r_rrp];
  assign u0_rdata_valid_o        = ~rst & ~w_rempty & ~w_rhead & rdata_valid_i;
  assign u1_rdata_valid_o        = ~rst & ~w_rempty & w_rhead & rdata_valid_i;
  assign u0_rdata_payload_data_o = rdata_payload_data_i;
  assign u1_rdata_payload_data_o = rdata_payload_data_i;
  assign w_rready                = ~rst & (w_rempty | (w_rhead ? u1_rdata_ready_i : u0_rdata_ready_i));
  assign rdata_ready_o           = w_rready;
  assign w_rpush                 = w_cmd_fire & ~w_cmd_we;
  assign w_rpop                  = ~w_rempty & rdata_valid_i & w_rready;

  assign err_o = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio    <= 1'b0;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
      r_err     <= 1'b0;
      r_wmem    <= '0;
      r_rmem    <= '0;
      r_wrp     <= '0;
      r_wwp     <= '0;
      r_rrp     <= '0;
      r_rwp     <= '0;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_prio <= ~w_gnt;
        r_lock <= 1'b0;
      end else if (w_cmd_valid) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_gnt;
      end
      if (rdata_valid_i && w_rempty) begin
        r_err <= 1'b1;
      end
      if (w_wpush) begin
        r_wmem[r_wwp] <= w_gnt;
        r_wwp         <= r_wwp + PW'(1);
      end
      if (w_wpop) begin
        r_wrp <= r_wrp + PW'(1);
      end
      r_wcnt <= r_wcnt + CW'(w_wpush) - CW'(w_wpop);
      if (w_rpush) begin
        r_rmem[r_rwp] <= w_gnt;
        r_rwp         <= r_rwp + PW'(1);
      end
      if (w_rpop) begin
        r_rrp <= r_rrp + PW'(1);
      end
      r_rcnt <= r_rcnt + CW'(w_rpush) - CW'(w_rpop);
    end
  end

endmodule

// File: tb/tb_native_port_arbiter.sv
// tb/tb_native_port_arbiter.sv - scoreboard bench for native_port_arbiter
// Stimulus pushes expected commands and beats into queues; a negedge monitor pops and compares.
module tb_native_port_arbiter;

  localparam int DW  = 128;
  localparam int MW  = 16;
  localparam int AW  = 28;
  localparam int OUT = 8;

  logic          clk, rst;
  logic          u0_ncmd_valid_i, u0_ncmd_ready_o, u0_ncmd_payload_we_i, u0_ncmd_payload_mw_i;
  logic [AW-1:0] u0_ncmd_payload_addr_i;
  logic          u0_wdata_valid_i, u0_wdata_ready_o;
  logic [DW-1:0] u0_wdata_payload_data_i;
  logic [MW-1:0] u0_wdata_payload_we_i;
  logic          u0_rdata_valid_o, u0_rdata_ready_i;
  logic [DW-1:0] u0_rdata_payload_data_o;
  logic          u1_ncmd_valid_i, u1_ncmd_ready_o, u1_ncmd_payload_we_i, u1_ncmd_payload_mw_i;
  logic [AW-1:0] u1_ncmd_payload_addr_i;
  logic          u1_wdata_valid_i, u1_wdata_ready_o;
  logic [DW-1:0] u1_wdata_payload_data_i;
  logic [MW-1:0] u1_wdata_payload_we_i;
  logic          u1_rdata_valid_o, u1_rdata_ready_i;
  logic [DW-1:0] u1_rdata_payload_data_o;
  logic          ncmd_valid_o, ncmd_ready_i, ncmd_payload_we_o, ncmd_payload_mw_o;
  logic [AW-1:0] ncmd_payload_addr_o;
  logic          wdata_valid_o, wdata_ready_i;
  logic [DW-1:0] wdata_payload_data_o;
  logic [MW-1:0] wdata_payload_we_o;
  logic          rdata_valid_i, rdata_ready_o;
  logic [DW-1:0] rdata_payload_data_i;
  logic          err_o;

  logic [AW+1:0]    q_cmd[$];
  logic [DW+MW-1:0] q_wd[$];
  logic [DW:0]      q_rd[$];
  int n_checks = 0;
  int n_errors = 0;

  native_port_arbiter #(.DDR_DATA_W(DW), .DDR_MASK_W(MW), .DDR_ADDR_W(AW), .OUTSTANDING(OUT)) dut (
    .clk(clk), .rst(rst),
    .u0_ncmd_valid_i(u0_ncmd_valid_i), .u0_ncmd_ready_o(u0_ncmd_ready_o),
    .u0_ncmd_payload_addr_i(u0_ncmd_payload_addr_i), .u0_ncmd_payload_we_i(u0_ncmd_payload_we_i),
    .u0_ncmd_payload_mw_i(u0_ncmd_payload_mw_i),
    .u0_wdata_valid_i(u0_wdata_valid_i), .u0_wdata_ready_o(u0_wdata_ready_o),
    .u0_wdata_payload_data_i(u0_wdata_payload_data_i), .u0_wdata_payload_we_i(u0_wdata_payload_we_i),
    .u0_rdata_valid_o(u0_rdata_valid_o), .u0_rdata_ready_i(u0_rdata_ready_i),
    .u0_rdata_payload_data_o(u0_rdata_payload_data_o),
    .u1_ncmd_valid_i(u1_ncmd_valid_i), .u1_ncmd_ready_o(u1_ncmd_ready_o),
    .u1_ncmd_payload_addr_i(u1_ncmd_payload_addr_i), .u1_ncmd_payload_we_i(u1_ncmd_payload_we_i),
    .u1_ncmd_payload_mw_i(u1_ncmd_payload_mw_i),
    .u1_wdata_valid_i(u1_wdata_valid_i), .u1_wdata_ready_o(u1_wdata_ready_o),
    .u1_wdata_payload_data_i(u1_wdata_payload_data_i), .u1_wdata_payload_we_i(u1_wdata_payload_we_i),
    .u1_rdata_valid_o(u1_rdata_valid_o), .u1_rdata_ready_i(u1_rdata_ready_i),
    .u1_rdata_payload_data_o(u1_rdata_payload_data_o),
    .ncmd_valid_o(ncmd_valid_o), .ncmd_ready_i(ncmd_ready_i),
    .ncmd_payload_addr_o(ncmd_payload_addr_o), .ncmd_payload_we_o(ncmd_payload_we_o),
    .ncmd_payload_mw_o(ncmd_payload_mw_o),
    .wdata_valid_o(wdata_valid_o), .wdata_ready_i(wdata_ready_i),
    .wdata_payload_data_o(wdata_payload_data_o), .wdata_payload_we_o(wdata_payload_we_o),
    .rdata_valid_i(rdata_valid_i), .rdata_ready_o(rdata_ready_o),
    .rdata_payload_data_i(rdata_payload_data_i),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [159:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0h expected no transfer", name, act);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ncmd_valid_o && ncmd_ready_i) begin
        if (q_cmd.size() == 0) unexpected("cmd_extra", {ncmd_payload_addr_o, ncmd_payload_we_o, ncmd_payload_mw_o});
        else check("cmd", {ncmd_payload_addr_o, ncmd_payload_we_o, ncmd_payload_mw_o}, q_cmd.pop_front());
      end
      if (wdata_valid_o && wdata_ready_i) begin
        if (q_wd.size() == 0) unexpected("wdata_extra", {wdata_payload_data_o, wdata_payload_we_o});
        else check("wdata", {wdata_payload_data_o, wdata_payload_we_o}, q_wd.pop_front());
      end
      if (u0_rdata_valid_o && u0_rdata_ready_i) begin
        if (q_rd.size() == 0) unexpected("rdata_u0_extra", {1'b0, u0_rdata_payload_data_o});
        else check("rdata_u0", {1'b0, u0_rdata_payload_data_o}, q_rd.pop_front());
      end
      if (u1_rdata_valid_o && u1_rdata_ready_i) begin
        if (q_rd.size() == 0) unexpected("rdata_u1_extra", {1'b1, u1_rdata_payload_data_o});
        else check("rdata_u1", {1'b1, u1_rdata_payload_data_o}, q_rd.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    u0_ncmd_valid_i = 0; u0_ncmd_payload_addr_i = '0; u0_ncmd_payload_we_i = 0; u0_ncmd_payload_mw_i = 0;
    u1_ncmd_valid_i = 0; u1_ncmd_payload_addr_i = '0; u1_ncmd_payload_we_i = 0; u1_ncmd_payload_mw_i = 0;
    u0_wdata_valid_i = 0; u0_wdata_payload_data_i = '0; u0_wdata_payload_we_i = '0;
    u1_wdata_valid_i = 0; u1_wdata_payload_data_i = '0; u1_wdata_payload_we_i = '0;
    u0_rdata_ready_i = 0; u1_rdata_ready_i = 0;
    ncmd_ready_i = 0; wdata_ready_i = 0; rdata_valid_i = 0; rdata_payload_data_i = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic check_idle(input string name);
    check(name, {ncmd_valid_o, u0_ncmd_ready_o, u1_ncmd_ready_o, wdata_valid_o, u0_wdata_ready_o,
                 u1_wdata_ready_o, u0_rdata_valid_o, u1_rdata_valid_o, rdata_ready_o, err_o}, 0);
    check({name, "_payload"}, {ncmd_payload_addr_o, ncmd_payload_we_o, ncmd_payload_mw_o,
                               wdata_payload_data_o[15:0], wdata_payload_we_o}, 0);
  endtask

  function automatic logic [AW+1:0] cmd(input logic [AW-1:0] a, input logic we, input logic mw);
    return {a, we, mw};
  endfunction

  initial begin
    clear_inputs();
    rst = 1;
    // reset with both requesters active and stray downstream traffic
    u0_ncmd_valid_i = 1; u0_ncmd_payload_addr_i = 28'h100;
    u1_ncmd_valid_i = 1; u1_ncmd_payload_addr_i = 28'h200;
    ncmd_ready_i = 1; wdata_ready_i = 1; rdata_valid_i = 1;
    u0_wdata_valid_i = 1; u0_wdata_payload_data_i = 128'hABCD; u0_rdata_ready_i = 1;
    @(negedge clk); check_idle("reset_c1");
    @(negedge clk); check_idle("reset_c2");
    @(posedge clk); #1;
    rst = 0; rdata_valid_i = 0; u0_wdata_valid_i = 0; u0_rdata_ready_i = 0;
    for (int i = 0; i < 2; i++) begin
      q_cmd.push_back(cmd(28'h100, 0, 0));
      q_cmd.push_back(cmd(28'h200, 0, 0));
    end
    @(negedge clk);
    check("first_grant", {u0_ncmd_ready_o, u1_ncmd_ready_o}, 2'b10);
    repeat (4) @(posedge clk);
    #1; u0_ncmd_valid_i = 0; u1_ncmd_valid_i = 0; ncmd_ready_i = 0; wdata_ready_i = 0;
    check("no_err_after_reset", err_o, 0);

    // grant lock under backpressure
    do_reset();
    u1_ncmd_valid_i = 1; u1_ncmd_payload_addr_i = 28'h300;
    @(negedge clk); check("lock_c0_addr", {ncmd_valid_o, ncmd_payload_addr_o}, {1'b1, 28'h300});
    @(posedge clk); #1;
    u0_ncmd_valid_i = 1; u0_ncmd_payload_addr_i = 28'h400;
    @(negedge clk); check("lock_c1_addr", {ncmd_payload_addr_o, u0_ncmd_ready_o}, {28'h300, 1'b0});
    @(posedge clk); #1;
    @(negedge clk); check("lock_c2_addr", ncmd_payload_addr_o, 28'h300);
    @(posedge clk); #1;
    ncmd_ready_i = 1;
    q_cmd.push_back(cmd(28'h300, 0, 0));
    q_cmd.push_back(cmd(28'h400, 0, 0));
    @(posedge clk); #1; u1_ncmd_valid_i = 0;
    @(posedge clk); #1; u0_ncmd_valid_i = 0; ncmd_ready_i = 0;

    // write ordering: u1 presents data early but must wait for u0's beat
    do_reset();
    u0_ncmd_valid_i = 1; u0_ncmd_payload_addr_i = 28'h500; u0_ncmd_payload_we_i = 1; u0_ncmd_payload_mw_i = 1;
    u1_ncmd_valid_i = 1; u1_ncmd_payload_addr_i = 28'h600; u1_ncmd_payload_we_i = 1;
    u1_wdata_valid_i = 1; u1_wdata_payload_data_i = 128'hBB; u1_wdata_payload_we_i = 16'hFF00;
    ncmd_ready_i = 1; wdata_ready_i = 1;
    q_cmd.push_back(cmd(28'h500, 1, 1));
    q_cmd.push_back(cmd(28'h600, 1, 0));
    @(negedge clk); check("wr_same_cycle_blocked", {wdata_valid_o, u1_wdata_ready_o}, 2'b00);
    @(posedge clk); #1; u0_ncmd_valid_i = 0;
    @(negedge clk); check("wr_u1_wait_c1", {wdata_valid_o, u1_wdata_ready_o}, 2'b00);
    @(posedge clk); #1; u1_ncmd_valid_i = 0;
    @(negedge clk); check("wr_u1_wait_c2", {wdata_valid_o, u1_wdata_ready_o}, 2'b00);
    @(posedge clk); #1;
    u0_wdata_valid_i = 1; u0_wdata_payload_data_i = 128'hAA; u0_wdata_payload_we_i = 16'h00FF;
    q_wd.push_back({128'hAA, 16'h00FF});
    q_wd.push_back({128'hBB, 16'hFF00});
    @(negedge clk); check("wr_u1_wait_c3", u1_wdata_ready_o, 0);
    @(posedge clk); #1; u0_wdata_valid_i = 0;
    @(posedge clk); #1; u1_wdata_valid_i = 0; wdata_ready_i = 0; ncmd_ready_i = 0;

    // read return steering
    do_reset();
    ncmd_ready_i = 1;
    u1_ncmd_valid_i = 1; u1_ncmd_payload_addr_i = 28'h700; q_cmd.push_back(cmd(28'h700, 0, 0));
    @(posedge clk); #1;
    u1_ncmd_valid_i = 0;
    u0_ncmd_valid_i = 1; u0_ncmd_payload_addr_i = 28'h710; q_cmd.push_back(cmd(28'h710, 0, 0));
    @(posedge clk); #1;
    u0_ncmd_valid_i = 0;
    u1_ncmd_valid_i = 1; u1_ncmd_payload_addr_i = 28'h720; q_cmd.push_back(cmd(28'h720, 0, 0));
    @(posedge clk); #1;
    u1_ncmd_valid_i = 0; ncmd_ready_i = 0;
    q_rd.push_back({1'b1, 128'h11});
    q_rd.push_back({1'b0, 128'h22});
    q_rd.push_back({1'b1, 128'h33});
    rdata_valid_i = 1; rdata_payload_data_i = 128'h11; u1_rdata_ready_i = 1;
    @(posedge clk); #1; rdata_payload_data_i = 128'h22;
    @(negedge clk);
    check("rd_stall", {rdata_ready_o, u0_rdata_valid_o, u1_rdata_valid_o}, 3'b010);
    @(posedge clk); #1; u0_rdata_ready_i = 1;
    @(posedge clk); #1; rdata_payload_data_i = 128'h33;
    @(posedge clk); #1; rdata_valid_i = 0; u0_rdata_ready_i = 0; u1_rdata_ready_i = 0;
    check("rd_no_err", err_o, 0);

    // owner FIFO full
    do_reset();
    ncmd_ready_i = 1;
    u0_ncmd_valid_i = 1; u0_ncmd_payload_addr_i = 28'h800;
    for (int i = 0; i < OUT; i++) q_cmd.push_back(cmd(28'h800, 0, 0));
    repeat (OUT) @(posedge clk);
    #1;
    @(negedge clk); check("full_blocked", {ncmd_valid_o, u0_ncmd_ready_o}, 2'b00);
    @(posedge clk); #1;
    u1_ncmd_valid_i = 1; u1_ncmd_payload_addr_i = 28'h900; u1_ncmd_payload_we_i = 1;
    q_cmd.push_back(cmd(28'h900, 1, 0));
    @(negedge clk); check("full_write_granted", u1_ncmd_ready_o, 1);
    @(posedge clk); #1;
    u1_ncmd_valid_i = 0;
    rdata_valid_i = 1; rdata_payload_data_i = 128'h55; u0_rdata_ready_i = 1;
    q_rd.push_back({1'b0, 128'h55});
    @(negedge clk); check("full_push_blocked_on_pop", ncmd_valid_o, 0);
    @(posedge clk); #1;
    rdata_valid_i = 0; u0_rdata_ready_i = 0;
    q_cmd.push_back(cmd(28'h800, 0, 0));
    @(negedge clk); check("full_unblocked", u0_ncmd_ready_o, 1);
    @(posedge clk); #1; u0_ncmd_valid_i = 0; ncmd_ready_i = 0;

    // spurious read data
    do_reset();
    rdata_valid_i = 1; rdata_payload_data_i = 128'h99; u0_rdata_ready_i = 1; u1_rdata_ready_i = 1;
    @(negedge clk);
    check("spur_drop", {rdata_ready_o, u0_rdata_valid_o, u1_rdata_valid_o, err_o}, 4'b1000);
    @(posedge clk); #1; rdata_valid_i = 0;
    @(negedge clk); check("spur_err_set", err_o, 1);
    repeat (3) @(posedge clk);
    @(negedge clk); check("spur_err_sticky", err_o, 1);
    do_reset();
    @(negedge clk); check("spur_err_cleared", err_o, 0);

    repeat (3) @(posedge clk);
    check("cmd_queue_drained", q_cmd.size(), 0);
    check("wdata_queue_drained", q_wd.size(), 0);
    check("rdata_queue_drained", q_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
